// File: rtl/axi4_lite_adc_bank.sv
// AXI4-Lite register bank: RW control words, a mode/snapshot CSR, sticky
// full-scale overrange flags and sign-extended ADC channel data registers.
module axi4_lite_adc_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_CTRL             = 2,
  parameter int N_CH               = 10,
  parameter int CH_WIDTH           = 24,
  parameter int C_S_AXI_ADDR_WIDTH = $clog2(N_CTRL + 2 + N_CH) + 2
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [N_CH*CH_WIDTH-1:0]        i_ch_data,
  input  logic [N_CH-1:0]                 i_ch_valid,
  output logic [N_CTRL*32-1:0]            o_ctrl,
  output logic                            o_snap_pulse
);

  localparam logic [31:0] CSR_IDX   = 32'(N_CTRL);
  localparam logic [31:0] OVR_IDX   = 32'(N_CTRL + 1);
  localparam logic [31:0] DATA_BASE = 32'(N_CTRL + 2);
  localparam logic [31:0] N_WORDS   = 32'(N_CTRL + 2 + N_CH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [CH_WIDTH-1:0] CH_MAX = {1'b0, {(CH_WIDTH-1){1'b1}}};
  localparam logic [CH_WIDTH-1:0] CH_MIN = {1'b1, {(CH_WIDTH-1){1'b0}}};

  logic                 awready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [1:0]           bresp_reg, rresp_reg;
  logic [31:0]          rdata_reg;
  logic [31:0]          ctrl_reg [N_CTRL];
  logic [31:0]          data_reg [N_CH];
  logic                 mode_reg;
  logic [15:0]          snap_cnt_reg;
  logic [N_CH-1:0]      ovr_reg;
  logic                 snap_pulse_reg;

  logic [31:0]          aw_idx, ar_idx;
  logic                 wr_en, rd_en, snap_wr;
  logic [1:0]           wr_resp, rd_resp;
  logic [31:0]          rd_data;
  logic [31:0]          wstrb_mask;
  logic [N_CH-1:0]      ovr_set, ovr_clr;
  logic [N_CH-1:0][31:0] ch_ext;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_idx  = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign ar_idx  = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);
  assign wr_en   = awready_reg && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en   = arready_reg && S_AXI_ARVALID;
  assign snap_wr = wr_en && (aw_idx == CSR_IDX) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
  assign wr_resp = (aw_idx >= N_WORDS) ? RESP_DECERR :
                   (aw_idx >= DATA_BASE) ? RESP_SLVERR : RESP_OKAY;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strb
      assign wstrb_mask[gi*8 +: 8] = {8{S_AXI_WSTRB[gi]}};
    end
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_ext[gi]  = 32'($signed(i_ch_data[gi*CH_WIDTH +: CH_WIDTH]));
      assign ovr_set[gi] = i_ch_valid[gi] &&
                           ((i_ch_data[gi*CH_WIDTH +: CH_WIDTH] == CH_MAX) ||
                            (i_ch_data[gi*CH_WIDTH +: CH_WIDTH] == CH_MIN));
    end
  endgenerate

  assign ovr_clr = (wr_en && aw_idx == OVR_IDX) ? (S_AXI_WDATA[N_CH-1:0] & wstrb_mask[N_CH-1:0])
                                                 : '0;

  // Read mux works from current register values, so a register updating in
  // the acceptance cycle returns its old contents.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_idx >= N_WORDS) begin
      rd_resp = RESP_DECERR;
    end else if (ar_idx == CSR_IDX) begin
      rd_data = {snap_cnt_reg, 14'd0, mode_reg, 1'b0};
    end else if (ar_idx == OVR_IDX) begin
      rd_data = 32'(ovr_reg);
    end
    for (int k = 0; k < N_CTRL; k++)
      if (ar_idx == 32'(k)) rd_data = ctrl_reg[k];
    for (int k = 0; k < N_CH; k++)
      if (ar_idx == DATA_BASE + 32'(k)) rd_data = data_reg[k];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
    end else begin
      awready_reg <= S_AXI_AWVALID && S_AXI_WVALID && !awready_reg && !bvalid_reg;
      if (wr_en) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_resp;
      end else if (S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
      arready_reg <= S_AXI_ARVALID && !arready_reg && !rvalid_reg;
      if (rd_en) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data;
        rresp_reg  <= rd_resp;
      end else if (S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int c = 0; c < N_CTRL; c++) ctrl_reg[c] <= '0;
      for (int k = 0; k < N_CH; k++) data_reg[k] <= '0;
      mode_reg       <= 1'b0;
      snap_cnt_reg   <= '0;
      ovr_reg        <= '0;
      snap_pulse_reg <= 1'b0;
      o_ctrl         <= '0;
    end else begin
      for (int c = 0; c < N_CTRL; c++)
        for (int b = 0; b < 4; b++)
          if (wr_en && aw_idx == 32'(c) && S_AXI_WSTRB[b])
            ctrl_reg[c][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      if (wr_en && aw_idx == CSR_IDX && S_AXI_WSTRB[0])
        mode_reg <= S_AXI_WDATA[1];
      if (snap_wr)
        snap_cnt_reg <= snap_cnt_reg + 16'd1;
      snap_pulse_reg <= snap_wr;
      // Set has priority over a coincident W1C clear.
      ovr_reg <= (ovr_reg & ~ovr_clr) | ovr_set;
      for (int k = 0; k < N_CH; k++)
        if (mode_reg ? snap_wr : i_ch_valid[k])
          data_reg[k] <= ch_ext[k];
      for (int c = 0; c < N_CTRL; c++)
        o_ctrl[c*32 +: 32] <= ctrl_reg[c];
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = awready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign o_snap_pulse  = snap_pulse_reg;

endmodule

// File: doc/axi4_lite_adc_bank.md
AXI4_LITE_ADC_BANK -- requirements
Module: axi4_lite_adc_bank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning register width, fixed at 32.
REQ-002 SHALL have parameter N_CTRL, default 2, meaning number of RW control registers (1..8).
REQ-003 SHALL have parameter N_CH, default 10, meaning number of ADC data channels (1..32).
REQ-004 SHALL have parameter CH_WIDTH, default 24, meaning per-channel sample width, signed two's complement (2..32).
REQ-005 SHALL have derived parameter C_S_AXI_ADDR_WIDTH = clog2(N_CTRL+2+N_CH)+2.
REQ-006 SHALL have port S_AXI_ACLK, input, width 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port S_AXI_ARESET, input, width 1, the reset: synchronous and active-high.
REQ-008 SHALL have the AXI4-Lite slave ports AW*/W*/B*/AR*/R* with standard names and widths; AWPROT and ARPROT are ignored.
REQ-009 SHALL have port i_ch_data, input, width N_CH*CH_WIDTH, channel k at bits [k*CH_WIDTH +: CH_WIDTH].
REQ-010 SHALL have port i_ch_valid, input, width N_CH, per-channel new-sample strobe.
REQ-011 SHALL have port o_ctrl, output, width N_CTRL*32, registered copies of the control registers.
REQ-012 SHALL have port o_snap_pulse, output, width 1, one-cycle pulse on each snapshot.

Function
REQ-013 Word address map SHALL be: 0..N_CTRL-1 CTRL (RW); N_CTRL CSR; N_CTRL+1 OVR flags; N_CTRL+2+k DATA[k] (RO).
REQ-014 A write SHALL be accepted only when AWVALID and WVALID are both high and no B response is pending; AWREADY and WREADY SHALL pulse high together for exactly one cycle.
REQ-015 BVALID SHALL assert the cycle after acceptance and hold until BREADY; no new write is accepted while BVALID is high.
REQ-016 ARREADY SHALL pulse for one cycle when ARVALID is high and RVALID is low; RVALID SHALL assert the next cycle with RDATA latched at acceptance, and hold until RREADY.
REQ-017 Responses SHALL be: OKAY for valid accesses; SLVERR for writes to DATA[k]; DECERR for an address beyond the map (RDATA=0). Rejected writes SHALL change no state.
REQ-018 CTRL writes SHALL honour WSTRB per byte; o_ctrl SHALL update one cycle after the register does.
REQ-019 CSR bit1 SHALL be MODE (RW): 0 = live, 1 = frozen.
REQ-020 CSR bit0 SHALL be SNAP (write-1 strobe, reads 0); bits[31:16] SHALL be SNAP_CNT (RO).
REQ-021 In live mode, DATA[k] SHALL load sign-extended i_ch_data[k] in every cycle in which i_ch_valid[k]=1.
REQ-022 In frozen mode, DATA[k] SHALL hold; a SNAP write SHALL load every channel's current i_ch_data in the same cycle, regardless of i_ch_valid.
REQ-023 On a SNAP write, SNAP_CNT SHALL increment modulo 2^16 (0xFFFF wraps to 0) and o_snap_pulse SHALL go high for one cycle, in either mode.
REQ-024 OVR[k] SHALL be set sticky when i_ch_valid[k]=1 and the sample equals the signed full-scale maximum or minimum code.
REQ-025 OVR bits SHALL clear on a write of 1 (W1C); if set and clear coincide, set SHALL win.
REQ-026 OVR bits N_CH..31 SHALL read 0.
REQ-027 A read and a write in progress simultaneously SHALL be served independently; a read of DATA[k] in the cycle it updates SHALL return the pre-update value.

Reset
REQ-028 When S_AXI_ARESET=1 at a clock edge, all of the following SHALL clear to 0 on that edge: CTRL, CSR (MODE, SNAP_CNT), OVR, DATA, o_ctrl, o_snap_pulse, and all READY/VALID/RESP/RDATA outputs.
REQ-029 Reset mid-transaction SHALL abort the transaction with no response issued.

Verification
REQ-030 Write 0xDEADBEEF to CTRL0 with WSTRB=0x3 -> OKAY; CTRL0 reads 0x0000BEEF; o_ctrl[31:0]=0x0000BEEF.
REQ-031 Live mode, CH_WIDTH=24: drive ch0=0x800000 with valid -> DATA[0] reads 0xFF800000 and OVR bit0=1; write OVR=0x1 -> reads 0.
REQ-032 Write MODE=1, change inputs, then SNAP -> DATA regs still old until SNAP, then all channels' new values; SNAP_CNT=1; o_snap_pulse high for 1 cycle.
REQ-033 Write to DATA[0] -> SLVERR, value unchanged; read of address beyond the map -> DECERR, RDATA=0.
REQ-034 Preload SNAP_CNT=0xFFFF via 65535 SNAPs, then SNAP -> SNAP_CNT=0; assert reset with BVALID pending -> BVALID=0 next cycle.
